// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t    : responder FSM states (IDLE, BUSY, RESP)
//   DWORD_W    : width of one stored doubleword
//   BYTE_OFS_W : number of byte-offset bits below the doubleword index
//   IDX_W      : width of the doubleword index taken from a 64-bit byte address
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int unsigned DWORD_W    = 64;
    localparam int unsigned BYTE_OFS_W = 3;
    localparam int unsigned IDX_W      = DWORD_W - BYTE_OFS_W;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage: synchronous write, combinational read on a shared address.
// Contents are not reset.
//   clk   : clock, write on rising edge
//   we    : write enable
//   addr  : doubleword index used for both read and write
//   wdata : write data
//   rdata : combinational read data at addr
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [DWORD_W-1:0] wdata,
    output logic [DWORD_W-1:0] rdata
);

    logic [DWORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed access latency.
// A request is accepted in IDLE, the response strobe appears exactly LATENCY cycles
// after the accept cycle, and stores commit at the end of the response cycle.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag Addr[2:0] != 0 as an error.
//   clk       : clock
//   rst_n     : synchronous active-low reset (array contents are kept)
//   MemReq    : access request
//   MemWrite  : 1 = store, 0 = load
//   Addr      : byte address
//   WriteData : store data
//   Ready     : high while a request can be accepted (IDLE only)
//   RespValid : one-cycle response strobe
//   ReadData  : load result during the response cycle, 0 otherwise
//   Err       : out-of-range (or trapped misaligned) access, during response only
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               MemReq,
    input  logic               MemWrite,
    input  logic [DWORD_W-1:0] Addr,
    input  logic [DWORD_W-1:0] WriteData,
    output logic               Ready,
    output logic               RespValid,
    output logic [DWORD_W-1:0] ReadData,
    output logic               Err
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_t             state_q;
    logic [3:0]         cnt_q;
    logic               ready_q;
    logic               resp_valid_q;

    logic               write_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DWORD_W-1:0] wdata_q;

    logic               accept;
    logic               access_ok;
    logic               array_we;
    logic [DWORD_W-1:0] array_rdata;

    assign accept = MemReq & ready_q;

    // Control FSM; Ready and RespValid are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q   <= CNT_INIT;
                        ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Request capture; only the accept cycle updates these, so inputs are ignored elsewhere.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= MemWrite;
            idx_q   <= Addr[DWORD_W-1:BYTE_OFS_W];
            wdata_q <= WriteData;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            misalign_q <= |Addr[BYTE_OFS_W-1:0];
        end
    end

    assign access_ok = (idx_q < IDX_W'(DEPTH)) & ~misalign_q;
`else
    assign access_ok = (idx_q < IDX_W'(DEPTH));
`endif

    // Gating with rst_n keeps a store aborted by reset in RESP from committing.
    assign array_we = (state_q == RESP) & write_q & access_ok & rst_n;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (array_we),
        .addr  (idx_q[AW-1:0]),
        .wdata (wdata_q),
        .rdata (array_rdata)
    );

    assign Ready     = ready_q;
    assign RespValid = resp_valid_q;
    assign ReadData  = (resp_valid_q & ~write_q & access_ok) ? array_rdata : '0;
    assign Err       = resp_valid_q & ~access_ok;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 / DEPTH=256 instance driven from a
// vector table plus hand-written abort/ignore sequences, and a LATENCY=1 / DEPTH=16
// instance for the back-to-back request pattern.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_write;
    logic [63:0] addr, write_data;
    logic        ready, resp_valid, err;
    logic [63:0] read_data;

    logic        mem_req1, mem_write1;
    logic [63:0] addr1, write_data1;
    logic        ready1, resp_valid1, err1;
    logic [63:0] read_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH   (256),
        .LATENCY (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemReq    (mem_req),
        .MemWrite  (mem_write),
        .Addr      (addr),
        .WriteData (write_data),
        .Ready     (ready),
        .RespValid (resp_valid),
        .ReadData  (read_data),
        .Err       (err)
    );

    dmem_responder #(
        .DEPTH   (16),
        .LATENCY (1)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemReq    (mem_req1),
        .MemWrite  (mem_write1),
        .Addr      (addr1),
        .WriteData (write_data1),
        .Ready     (ready1),
        .RespValid (resp_valid1),
        .ReadData  (read_data1),
        .Err       (err1)
    );

    typedef struct {
        logic        wr;
        logic [63:0] a;
        logic [63:0] d;
        logic        exp_err;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One complete access on dut; lat counts cycles from the accept cycle to RespValid.
    task automatic access(input logic wr, input logic [63:0] a, input logic [63:0] d,
                          output logic [63:0] rd, output logic er, output int lat);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", {63'd0, ready}, 64'd1);
        mem_req = 1'b1; mem_write = wr; addr = a; write_data = d;
        @(negedge clk);
        mem_req = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) lat = -1;
        rd = read_data;
        er = err;
    endtask

    function automatic vec_t mk(logic wr, logic [63:0] a, logic [63:0] d, logic e,
                                logic [63:0] r);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.exp_err = e; v.exp_rd = r;
        return v;
    endfunction

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          cnt;

        rst_n = 1'b0;
        mem_req = 0; mem_write = 0; addr = 0; write_data = 0;
        mem_req1 = 0; mem_write1 = 0; addr1 = 0; write_data1 = 0;

        vecs.push_back(mk(1, 64'h10,  64'hDEADBEEF_CAFEF00D, 0, 64'h0));
        vecs.push_back(mk(0, 64'h10,  64'h0,                 0, 64'hDEADBEEF_CAFEF00D));
        vecs.push_back(mk(1, 64'h0,   64'h11112222_33334444, 0, 64'h0));
        vecs.push_back(mk(1, 64'h7F8, 64'hAAAA5555_0F0FF0F0, 0, 64'h0));
        vecs.push_back(mk(0, 64'h7F8, 64'h0,                 0, 64'hAAAA5555_0F0FF0F0));
        vecs.push_back(mk(1, 64'h800, 64'h99999999_99999999, 1, 64'h0));
        vecs.push_back(mk(0, 64'h800, 64'h0,                 1, 64'h0));
        vecs.push_back(mk(0, 64'h0,   64'h0,                 0, 64'h11112222_33334444));
        vecs.push_back(mk(1, 64'hFFFFFFFF_FFFFFFF8, 64'h77, 1, 64'h0));
        vecs.push_back(mk(0, 64'h0,   64'h0,                 0, 64'h11112222_33334444));
        vecs.push_back(mk(1, 64'h18,  64'h01234567_89ABCDEF, 0, 64'h0));
        vecs.push_back(mk(0, 64'h18,  64'h0,                 0, 64'h01234567_89ABCDEF));
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 64'h13,  64'h0,                 1, 64'h0));
`else
        vecs.push_back(mk(0, 64'h13,  64'h0,                 0, 64'hDEADBEEF_CAFEF00D));
`endif
        // Preloads for the ignore / abort sequences below.
        vecs.push_back(mk(1, 64'h28,  64'h55555555_00000005, 0, 64'h0));
        vecs.push_back(mk(1, 64'h30,  64'h66666666_00000006, 0, 64'h0));
        vecs.push_back(mk(1, 64'h38,  64'h88888888_00000008, 0, 64'h0));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_read_data", read_data, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_ready1", {63'd0, ready1}, 64'd1);
        rst_n = 1'b1;

        // LATENCY=1 with the request held high: Ready 1,0,1,0..., RespValid every 2 cycles
        @(negedge clk);
        mem_req1 = 1'b1; mem_write1 = 1'b1; addr1 = 64'h8; write_data1 = 64'h1234;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("l1_ready_%0d", i), {63'd0, ready1}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("l1_resp_%0d", i), {63'd0, resp_valid1},
                (i % 2 == 0) ? 64'd0 : 64'd1);
            @(negedge clk);
        end
        mem_req1 = 1'b0;

        // Table-driven accesses
        foreach (vecs[i]) begin
            access(vecs[i].wr, vecs[i].a, vecs[i].d, rd, er, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
            chk($sformatf("v%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_read_data", i), rd, vecs[i].exp_rd);
            @(negedge clk);
            chk($sformatf("v%0d_idle_read_data", i), read_data, 64'd0);
            chk($sformatf("v%0d_idle_err", i), {63'd0, err}, 64'd0);
        end

        // Request while BUSY/RESP is ignored
        @(negedge clk);
        chk("ign_ready", {63'd0, ready}, 64'd1);
        mem_req = 1'b1; mem_write = 1'b1; addr = 64'h20; write_data = 64'h44444444_00000004;
        @(negedge clk);
        chk("ign_busy_ready", {63'd0, ready}, 64'd0);
        addr = 64'h28; write_data = 64'hBAD0BAD0_BAD0BAD0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) begin
                cnt++;
                mem_req = 1'b0;
            end
            @(negedge clk);
        end
        mem_req = 1'b0; mem_write = 1'b0;
        chk("ign_resp_count", 64'(cnt), 64'd1);
        access(1'b0, 64'h28, 64'h0, rd, er, lat);
        chk("ign_idx5_unchanged", rd, 64'h55555555_00000005);
        access(1'b0, 64'h20, 64'h0, rd, er, lat);
        chk("ign_idx4_written", rd, 64'h44444444_00000004);

        // Reset during BUSY aborts the store
        @(negedge clk);
        mem_req = 1'b1; mem_write = 1'b1; addr = 64'h30; write_data = 64'h77777777_00000007;
        @(negedge clk);
        mem_req = 1'b0; mem_write = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) cnt++;
            @(negedge clk);
        end
        chk("abort_busy_resp_count", 64'(cnt), 64'd0);
        chk("abort_busy_ready", {63'd0, ready}, 64'd1);
        access(1'b0, 64'h30, 64'h0, rd, er, lat);
        chk("abort_busy_old_data", rd, 64'h66666666_00000006);

        // Reset during RESP aborts the store commit
        @(negedge clk);
        mem_req = 1'b1; mem_write = 1'b1; addr = 64'h38; write_data = 64'h99999999_00000009;
        @(negedge clk);
        mem_req = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("abort_resp_in_resp", {63'd0, resp_valid}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_resp_no_strobe", {63'd0, resp_valid}, 64'd0);
        access(1'b0, 64'h38, 64'h0, rd, er, lat);
        chk("abort_resp_old_data", rd, 64'h88888888_00000008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 64-bit doublewords stored.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from accept to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port MemReq, input, 1, access request from the memory-access stage.
REQ-006 SHALL have port MemWrite, input, 1; 1 = store, 0 = load, qualified by MemReq.
REQ-007 SHALL have port Addr, input, 64, byte address.
REQ-008 SHALL have port WriteData, input, 64, store data.
REQ-009 SHALL have port Ready, output, 1; high = a request is accepted this cycle.
REQ-010 SHALL have port RespValid, output, 1, one-cycle response strobe.
REQ-011 SHALL have port ReadData, output, 64, load result, valid only with RespValid on a load.
REQ-012 SHALL have port Err, output, 1, error flag, valid only with RespValid.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 SHALL drive Ready=1 only in IDLE.
REQ-015 SHALL accept a request when MemReq=1 and Ready=1; it SHALL then latch MemWrite, Addr, WriteData and load the latency counter with LATENCY-1.
REQ-016 On accept, the FSM SHALL go to RESP if LATENCY=1, else to BUSY.
REQ-017 In BUSY, the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the cycle the counter reaches 1.
REQ-018 RESP SHALL last exactly one cycle with RespValid=1, then return to IDLE; the first accept cycle to RespValid cycle spans exactly LATENCY cycles.
REQ-019 Index SHALL be latched Addr[63:3]; the access is in range iff index < DEPTH.
REQ-020 An in-range store SHALL write latched WriteData to the array at the RESP edge; Err=0.
REQ-021 An in-range load SHALL present the array word in the RESP cycle; Err=0.
REQ-022 An out-of-range access SHALL NOT modify the array; a load returns ReadData=0; Err=1.
REQ-023 MemReq, MemWrite, Addr and WriteData SHALL be ignored outside IDLE; no queuing is performed.
REQ-024 In RESP, Ready=0, so back-to-back accesses are spaced at least LATENCY+1 cycles apart.
REQ-025 Outside RESP, ReadData SHALL be 0 and Err SHALL be 0.
REQ-026 A load following a store to the same index SHALL return the stored value.

Reset
REQ-027 With rst_n=0 at a clock edge: state=IDLE, counter=0, Ready=1 after the edge, RespValid=0, ReadData=0, Err=0.
REQ-028 Reset mid-access (BUSY or RESP) SHALL abort the access; a pending store SHALL NOT be written; no RespValid follows.
REQ-029 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DMEM_MISALIGN_TRAP_EN defined: latched Addr[2:0]!=0 SHALL be treated as an error with identical handling to out-of-range (no write, ReadData=0, Err=1).
REQ-031 Macro DMEM_MISALIGN_TRAP_EN undefined: Addr[2:0] SHALL be ignored, and misaligned accesses proceed on index Addr[63:3].

Structure
REQ-032 Package dmem_pkg SHALL hold: the state enum typedef (IDLE, BUSY, RESP); constant DWORD_W=64; constant BYTE_OFS_W=3.
REQ-033 Storage SHALL be sub-module dmem_array (synchronous write, combinational read, DEPTH x 64); the FSM, counter and range/alignment check live in dmem_responder.

Verification
REQ-034 Reset, then store Addr=0x10, data 0xDEADBEEF_CAFEF00D; load Addr=0x10 -> RespValid exactly 2 cycles after each accept, load ReadData=0xDEADBEEF_CAFEF00D, Err=0.
REQ-035 LATENCY=1: request held high continuously -> Ready toggles 1,0,1,0; one RespValid every 2 cycles.
REQ-036 Load Addr=8*DEPTH (0x800 at DEPTH=256) -> Err=1, ReadData=0; a prior word at index 0 is unchanged.
REQ-037 Store Addr=0x20; then, while BUSY, drive MemReq with Addr=0x28 -> ignored; only one RespValid; index 5 unchanged.
REQ-038 Store to 0x30, assert rst_n=0 during BUSY -> no RespValid; a later load of 0x30 returns the old contents.
REQ-039 Load Addr=0x13 -> with DMEM_MISALIGN_TRAP_EN: Err=1, ReadData=0; without it: Err=0, returns the word at index 2.
